// File: rtl/rs_issue_scheduler.sv
// rs_issue_scheduler
//   Issue-select controller for a reservation station. Each cycle it picks one ready
//   row, starting the search at a round-robin pointer. The picked row is presented to the
//   functional unit over a valid/ready handshake. After the handshake, a one-cycle clear
//   pulse tells the RS to free that row.
// Ports
//   i_clk, i_rst          clock; synchronous active-high reset
//   i_entry_valid         per-row occupancy
//   i_src1_ready          per-row source-1 operand availability
//   i_src2_ready          per-row source-2 operand availability
//   i_flush               squash presentation and issued-row tracking
//   i_issue_ready         FU accepts the presented row this cycle
//   o_issue_valid         a row is being presented
//   o_issue_idx           index of the presented row
//   o_clear_valid         one-cycle pulse: free row o_clear_idx
//   o_clear_idx           index of the row to free
//   o_rr_ptr              round-robin search start index
//   o_stall_cnt           saturating count of presented-but-not-accepted cycles
module rs_issue_scheduler #(
    parameter int unsigned RS_ROW_COUNT = 64,
    parameter int unsigned IDX_W        = $clog2(RS_ROW_COUNT)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [RS_ROW_COUNT-1:0] i_entry_valid,
    input  logic [RS_ROW_COUNT-1:0] i_src1_ready,
    input  logic [RS_ROW_COUNT-1:0] i_src2_ready,
    input  logic                    i_flush,
    input  logic                    i_issue_ready,
    output logic                    o_issue_valid,
    output logic [IDX_W-1:0]        o_issue_idx,
    output logic                    o_clear_valid,
    output logic [IDX_W-1:0]        o_clear_idx,
    output logic [IDX_W-1:0]        o_rr_ptr,
    output logic [15:0]             o_stall_cnt
);

    typedef enum logic {
        ST_IDLE,
        ST_HOLD
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RS_ROW_COUNT - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [IDX_W-1:0]        r_issue_idx;
    logic [IDX_W-1:0]        w_issue_idx_nxt;
    logic                    r_clear_valid;
    logic [IDX_W-1:0]        r_clear_idx;
    logic [IDX_W-1:0]        r_rr_ptr;
    logic [15:0]             r_stall_cnt;
    logic [RS_ROW_COUNT-1:0] r_issued_mask;

    logic [RS_ROW_COUNT-1:0] w_eligible;
    logic [RS_ROW_COUNT-1:0] w_hs_mask;
    logic [IDX_W:0]          w_scan_pos;
    logic [IDX_W-1:0]        w_sel_idx;
    logic                    w_sel_found;
    logic                    w_row_live;
    logic                    w_hs;
    logic                    w_stall;

    assign w_row_live = i_entry_valid[r_issue_idx];
    // A handshake on a row that has just left the RS, or one squashed by flush,
    // does not count as an issue: no clear pulse and no pointer advance.
    assign w_hs    = (r_state == ST_HOLD) & i_issue_ready & w_row_live & ~i_flush;
    assign w_stall = (r_state == ST_HOLD) & ~i_issue_ready;

    always_comb begin
        w_eligible = i_entry_valid & i_src1_ready & i_src2_ready & ~r_issued_mask;
        if (r_state == ST_HOLD) begin
            w_eligible[r_issue_idx] = 1'b0;
        end
        w_hs_mask              = '0;
        w_hs_mask[r_issue_idx] = w_hs;
    end

    // The scan runs from the farthest offset down to offset 0. Later hits overwrite
    // earlier ones, so the nearest eligible row at or after r_rr_ptr wins.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        w_scan_pos  = '0;
        for (int unsigned k = RS_ROW_COUNT; k != 0; k--) begin
            w_scan_pos = {1'b0, r_rr_ptr} + (IDX_W + 1)'(k - 1);
            if (w_scan_pos >= (IDX_W + 1)'(RS_ROW_COUNT)) begin
                w_scan_pos = w_scan_pos - (IDX_W + 1)'(RS_ROW_COUNT);
            end
            if (w_eligible[w_scan_pos[IDX_W-1:0]]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = w_scan_pos[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_issue_idx_nxt = r_issue_idx;
        if (i_flush) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_sel_found) begin
                        w_state_nxt     = ST_HOLD;
                        w_issue_idx_nxt = w_sel_idx;
                    end
                end
                ST_HOLD: begin
                    // A completed issue or a vanished row frees the slot. Refill it
                    // at once so back-to-back issue sustains one row per cycle.
                    if (w_hs || !w_row_live) begin
                        if (w_sel_found) begin
                            w_issue_idx_nxt = w_sel_idx;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_issue_idx   <= '0;
            r_clear_valid <= 1'b0;
            r_clear_idx   <= '0;
            r_rr_ptr      <= '0;
            r_stall_cnt   <= '0;
            r_issued_mask <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_issue_idx   <= w_issue_idx_nxt;
            r_clear_valid <= w_hs;
            if (w_hs) begin
                r_clear_idx <= r_issue_idx;
                r_rr_ptr    <= (r_issue_idx == LAST_IDX) ? '0 : r_issue_idx + IDX_W'(1);
            end
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (i_flush) begin
                r_issued_mask <= '0;
            end else begin
                r_issued_mask <= (r_issued_mask | w_hs_mask) & i_entry_valid;
            end
        end
    end

    assign o_issue_valid = (r_state == ST_HOLD);
    assign o_issue_idx   = r_issue_idx;
    assign o_clear_valid = r_clear_valid;
    assign o_clear_idx   = r_clear_idx;
    assign o_rr_ptr      = r_rr_ptr;
    assign o_stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// tb_rs_issue_scheduler
//   Self-checking bench for rs_issue_scheduler. It applies directed tables, hand-written
//   corner sequences and random traffic. A behavioural reference model supplies the
//   expected values.
module tb_rs_issue_scheduler;

    localparam int N = 64;
    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] ev, s1, s2;
    logic         flush, rdy;
    logic         o_issue_valid, o_clear_valid;
    logic [W-1:0] o_issue_idx, o_clear_idx, o_rr_ptr;
    logic [15:0]  o_stall_cnt;

    always #5 clk = ~clk;

    rs_issue_scheduler #(.RS_ROW_COUNT(N), .IDX_W(W)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_entry_valid (ev),
        .i_src1_ready  (s1),
        .i_src2_ready  (s2),
        .i_flush       (flush),
        .i_issue_ready (rdy),
        .o_issue_valid (o_issue_valid),
        .o_issue_idx   (o_issue_idx),
        .o_clear_valid (o_clear_valid),
        .o_clear_idx   (o_clear_idx),
        .o_rr_ptr      (o_rr_ptr),
        .o_stall_cnt   (o_stall_cnt)
    );

    int errors = 0;
    int checks = 0;
    bit do_chk = 1'b1;

    // Reference model state
    bit m_busy;
    int m_idx, m_rr, m_stall, m_clr_idx;
    bit m_clr_v;
    bit m_mask[N];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] row(input int a);
        logic [N-1:0] r;
        r    = '0;
        r[a] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_idx = 0; m_rr = 0; m_stall = 0; m_clr_idx = 0; m_clr_v = 0;
        for (int i = 0; i < N; i++) m_mask[i] = 0;
    endtask

    // One clock of behaviour, computed from the pre-edge inputs and state
    task automatic model_step();
        int pick;
        bit hs;
        if (rst) begin
            model_reset();
            return;
        end
        pick = -1;
        for (int d = 0; d < N; d++) begin
            int j;
            j = (m_rr + d) % N;
            if (pick < 0 && ev[j] && s1[j] && s2[j] && !m_mask[j] && !(m_busy && j == m_idx))
                pick = j;
        end
        hs = m_busy && rdy && ev[m_idx] && !flush;
        if (m_busy && !rdy && m_stall < 65535) m_stall++;
        for (int i = 0; i < N; i++)
            m_mask[i] = !flush && ev[i] && (m_mask[i] || (hs && i == m_idx));
        m_clr_v = hs;
        if (hs) begin
            m_clr_idx = m_idx;
            m_rr      = (m_idx + 1) % N;
        end
        if (flush) begin
            m_busy = 0;
        end else if (!m_busy) begin
            if (pick >= 0) begin
                m_busy = 1;
                m_idx  = pick;
            end
        end else if (hs || !ev[m_idx]) begin
            if (pick >= 0) m_idx = pick;
            else m_busy = 0;
        end
    endtask

    task automatic compare_model();
        chk("issue_valid", o_issue_valid, m_busy);
        chk("issue_idx", o_issue_idx, m_idx);
        chk("clear_valid", o_clear_valid, m_clr_v);
        chk("clear_idx", o_clear_idx, m_clr_idx);
        chk("rr_ptr", o_rr_ptr, m_rr);
        chk("stall_cnt", o_stall_cnt, m_stall);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        if (do_chk) compare_model();
    endtask

    typedef struct {
        logic [N-1:0] ev;
        logic         rdy;
        logic         e_valid;
        int           e_idx;
        logic         e_clr;
        int           e_clr_idx;
        int           e_rr;
    } vec_t;

    vec_t tbl[12];

    initial begin
        rst = 1'b1; ev = '0; s1 = '1; s2 = '1; flush = 1'b0; rdy = 1'b1;
        model_reset();

        // Reset state
        cycle();
        cycle();
        chk("rst_issue_valid", o_issue_valid, 0);
        chk("rst_issue_idx", o_issue_idx, 0);
        chk("rst_clear_valid", o_clear_valid, 0);
        chk("rst_clear_idx", o_clear_idx, 0);
        chk("rst_rr_ptr", o_rr_ptr, 0);
        chk("rst_stall_cnt", o_stall_cnt, 0);
        rst = 1'b0;

        // Rows 3 and 10 back-to-back, then a wrap from rr_ptr 62 over rows 63 and 1
        tbl[0]  = '{row(3) | row(10), 1'b1, 1'b1,  3, 1'b0,  0, 11 - 11};
        tbl[1]  = '{row(3) | row(10), 1'b1, 1'b1, 10, 1'b1,  3,  4};
        tbl[2]  = '{row(3) | row(10), 1'b1, 1'b0, 10, 1'b1, 10, 11};
        tbl[3]  = '{row(3) | row(10), 1'b1, 1'b0, 10, 1'b0, 10, 11};
        tbl[4]  = '{'0,               1'b1, 1'b0, 10, 1'b0, 10, 11};
        tbl[5]  = '{row(61),          1'b1, 1'b1, 61, 1'b0, 10, 11};
        tbl[6]  = '{row(61),          1'b1, 1'b0, 61, 1'b1, 61, 62};
        tbl[7]  = '{'0,               1'b1, 1'b0, 61, 1'b0, 61, 62};
        tbl[8]  = '{row(1) | row(63), 1'b1, 1'b1, 63, 1'b0, 61, 62};
        tbl[9]  = '{row(1) | row(63), 1'b1, 1'b1,  1, 1'b1, 63,  0};
        tbl[10] = '{row(1) | row(63), 1'b1, 1'b0,  1, 1'b1,  1,  2};
        tbl[11] = '{'0,               1'b1, 1'b0,  1, 1'b0,  1,  2};
        for (int t = 0; t < 12; t++) begin
            ev  = tbl[t].ev;
            rdy = tbl[t].rdy;
            cycle();
            chk($sformatf("tbl%0d_valid", t), o_issue_valid, tbl[t].e_valid);
            chk($sformatf("tbl%0d_idx", t), o_issue_idx, tbl[t].e_idx);
            chk($sformatf("tbl%0d_clr", t), o_clear_valid, tbl[t].e_clr);
            chk($sformatf("tbl%0d_clr_idx", t), o_clear_idx, tbl[t].e_clr_idx);
            chk($sformatf("tbl%0d_rr", t), o_rr_ptr, tbl[t].e_rr);
        end

        // Stall: row 5 held for 4 cycles, row 2 arriving meanwhile does not preempt
        ev = row(5); rdy = 1'b0;
        cycle();
        chk("stall_present", o_issue_idx, 5);
        for (int k = 0; k < 4; k++) begin
            if (k == 1) ev = row(5) | row(2);
            cycle();
            chk("stall_hold_idx", o_issue_idx, 5);
            chk("stall_hold_valid", o_issue_valid, 1);
        end
        chk("stall_cnt4", o_stall_cnt, 4);
        rdy = 1'b1;
        cycle();
        chk("stall_next_idx", o_issue_idx, 2);
        chk("stall_clear5", o_clear_idx, 5);
        cycle();
        ev = '0;
        cycle();

        // Flush in the same cycle as the handshake on row 7
        ev = row(7); rdy = 1'b0;
        cycle();
        chk("flush_present", o_issue_idx, 7);
        flush = 1'b1; rdy = 1'b1;
        cycle();
        chk("flush_valid", o_issue_valid, 0);
        chk("flush_clear", o_clear_valid, 0);
        chk("flush_rr", o_rr_ptr, 3);
        flush = 1'b0; ev = '0;
        cycle();

        // Row 9 stays occupied after issue: no re-issue until it leaves
        ev = row(9);
        cycle();
        chk("r9_present", o_issue_idx, 9);
        cycle();
        chk("r9_clear", o_clear_valid, 1);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("r9_no_reissue", o_issue_valid, 0);
            chk("r9_single_clear", o_clear_valid, 0);
        end
        ev = '0;
        cycle();
        ev = row(9);
        cycle();
        chk("r9_reissue_valid", o_issue_valid, 1);
        chk("r9_reissue_idx", o_issue_idx, 9);
        cycle();
        ev = '0;
        cycle();

        // Reset while a row is presented
        ev = row(4); rdy = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        chk("midrst_valid", o_issue_valid, 0);
        chk("midrst_idx", o_issue_idx, 0);
        chk("midrst_rr", o_rr_ptr, 0);
        chk("midrst_stall", o_stall_cnt, 0);
        rst = 1'b0; ev = '0;
        cycle();

        // Stall counter saturation
        ev = row(0); rdy = 1'b0;
        do_chk = 1'b0;
        cycle();
        for (int k = 0; k < 65534; k++) cycle();
        do_chk = 1'b1;
        chk("sat_fffe", o_stall_cnt, 16'hFFFE);
        for (int k = 0; k < 3; k++) cycle();
        chk("sat_ffff", o_stall_cnt, 16'hFFFF);
        rst = 1'b1; ev = '0;
        cycle();
        rst = 1'b0;

        // Random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            ev    = {$urandom, $urandom} & {$urandom, $urandom};
            s1    = {$urandom, $urandom} | {$urandom, $urandom};
            s2    = {$urandom, $urandom} | {$urandom, $urandom};
            rdy   = ($urandom_range(3) != 0);
            flush = ($urandom_range(31) == 0);
            rst   = ($urandom_range(255) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
